// File: rtl/iiitb_freqdiv_pkg.sv
// Shared definitions for the frequency measurement block: FSM state encoding
// and the default phase-counter width.
package iiitb_freqdiv_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ARM  = 2'd1;
  localparam state_t HIGH = 2'd2;
  localparam state_t LOW  = 2'd3;

endpackage

// File: rtl/iiitb_edge_det.sv
// Two-stage register on the clkin-derived signal plus rise/fall decode.
// No synchronizer: the input is already in the clkin domain.
module iiitb_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic sig_in,
  output logic rise_c,
  output logic fall_c
);

  logic sig_q, sig_d;
  logic sig_qq, sig_qq_d;

  // Next values of the two sampling stages; clr flushes both.
  always_comb begin
    sig_d    = sig_in;
    sig_qq_d = sig_q;
    if (clr) begin
      sig_d    = 1'b0;
      sig_qq_d = 1'b0;
    end
  end

  // Sampling stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q  <= 1'b0;
      sig_qq <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      sig_qq <= sig_qq_d;
    end
  end

  assign rise_c = sig_q & ~sig_qq;
  assign fall_c = ~sig_q & sig_qq;

endmodule

// File: rtl/iiitb_freqmeas.sv
// Period / high-time meter for a clkin-derived divided clock, with a
// valid/ready result port, sticky overrun and a stuck-signal flag.
// Optional macro FREQMEAS_CHECK_EN adds exp_period input and mismatch output.
module iiitb_freqmeas
  import iiitb_freqdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W:0]   period,
  output logic [CNT_W-1:0] high_time,
  output logic             overrun,
  output logic             stuck
`ifdef FREQMEAS_CHECK_EN
  ,
  input  logic [CNT_W:0]   exp_period,
  output logic             mismatch
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rise_c, fall_c;
  logic             capture_c;
  logic [CNT_W:0]   sum_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W:0]   period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             overrun_q, overrun_d;
  logic             stuck_q, stuck_d;
`ifdef FREQMEAS_CHECK_EN
  logic             mismatch_q, mismatch_d;
`endif

  iiitb_edge_det u_edge_det (
    .clk    (clkin),
    .rst    (rst),
    .clr    (~en),
    .sig_in (sig_in),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // FSM, phase counters and result handshake.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    valid_d   = valid_q;
    period_d  = period_q;
    high_d    = high_q;
    overrun_d = overrun_q;
    stuck_d   = stuck_q;
    capture_c = 1'b0;
    sum_c     = (CNT_W+1)'(hcnt_q) + (CNT_W+1)'(lcnt_q);
`ifdef FREQMEAS_CHECK_EN
    mismatch_d = mismatch_q;
`endif

    case (state_q)
      IDLE: begin
        if (en) state_d = ARM;
      end
      // Wait for the first rise; that phase is partial so nothing is captured.
      ARM: begin
        if (rise_c) begin
          state_d = HIGH;
          hcnt_d  = CNT_ONE;
        end
      end
      // A saturated counter means the signal stopped toggling.
      HIGH: begin
        if (hcnt_q == CNT_MAX) begin
          stuck_d = 1'b1;
          state_d = ARM;
        end else if (fall_c) begin
          state_d = LOW;
          lcnt_d  = CNT_ONE;
        end else begin
          hcnt_d = hcnt_q + CNT_ONE;
        end
      end
      LOW: begin
        if (lcnt_q == CNT_MAX) begin
          stuck_d = 1'b1;
          state_d = ARM;
        end else if (rise_c) begin
          state_d   = HIGH;
          hcnt_d    = CNT_ONE;
          capture_c = 1'b1;
        end else begin
          lcnt_d = lcnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new result loads if the slot is free or being drained this cycle.
    if (capture_c) begin
      if (!valid_q || meas_ready) begin
        valid_d  = 1'b1;
        period_d = sum_c;
        high_d   = hcnt_q;
        stuck_d  = 1'b0;
`ifdef FREQMEAS_CHECK_EN
        mismatch_d = (sum_c != exp_period);
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
`ifdef FREQMEAS_CHECK_EN
      mismatch_d = 1'b0;
`endif
    end

    // Disabling behaves like a synchronous reset and discards any result.
    if (!en) begin
      state_d   = IDLE;
      hcnt_d    = '0;
      lcnt_d    = '0;
      valid_d   = 1'b0;
      period_d  = '0;
      high_d    = '0;
      overrun_d = 1'b0;
      stuck_d   = 1'b0;
`ifdef FREQMEAS_CHECK_EN
      mismatch_d = 1'b0;
`endif
    end
  end

  // State and result registers.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      valid_q   <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      overrun_q <= 1'b0;
      stuck_q   <= 1'b0;
`ifdef FREQMEAS_CHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      high_q    <= high_d;
      overrun_q <= overrun_d;
      stuck_q   <= stuck_d;
`ifdef FREQMEAS_CHECK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign meas_valid = valid_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign overrun    = overrun_q;
  assign stuck      = stuck_q;
`ifdef FREQMEAS_CHECK_EN
  assign mismatch   = mismatch_q;
`endif

endmodule

// File: doc/iiitb_freqmeas.md
IIITB_FREQMEAS -- requirements
Module: iiitb_freqmeas

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the high and low phase counters.
REQ-002 The module SHALL have port clkin, input, 1 bit: the single clock; all state updates on its posedge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port en, input, 1 bit: measurement enable.
REQ-005 The module SHALL have port sig_in, input, 1 bit: the divided clock under measurement (the divider's clkout), derived from clkin.
REQ-006 The module SHALL have port meas_valid, output, 1 bit: a result is pending.
REQ-007 The module SHALL have port meas_ready, input, 1 bit: the consumer accepts the result.
REQ-008 The module SHALL have port period, output, CNT_W+1 bits: measured period in clkin cycles.
REQ-009 The module SHALL have port high_time, output, CNT_W bits: measured high phase in clkin cycles.
REQ-010 The module SHALL have port overrun, output, 1 bit: sticky flag, a result was dropped.
REQ-011 The module SHALL have port stuck, output, 1 bit: sig_in showed no edge within the counter range.

Function
REQ-012 sig_in SHALL be registered once (sig_q) and again (sig_qq) with no synchronizer, since it is clkin-derived; rise = sig_q & ~sig_qq, fall = ~sig_q & sig_qq.
REQ-013 FSM states SHALL be IDLE, ARM, HIGH, LOW; en=0 forces IDLE from any state on the next edge.
REQ-014 Transitions: IDLE->ARM when en=1; ARM->HIGH on rise; HIGH->LOW on fall; LOW->HIGH on rise.
REQ-015 On entering HIGH, hcnt SHALL load 1; hcnt increments each later cycle spent in HIGH. On entering LOW, lcnt SHALL load 1 and increment likewise.
REQ-016 On a LOW->HIGH transition, the block SHALL capture period=hcnt+lcnt (zero-extended, no truncation) and high_time=hcnt, and assert meas_valid on the following cycle.
REQ-017 On the first ARM->HIGH transition, the block SHALL produce no result (partial phase).
REQ-018 If hcnt or lcnt reaches all-ones, the block SHALL set stuck, return to ARM, and produce no result.
REQ-019 meas_valid with period and high_time SHALL hold stable until the meas_valid&meas_ready cycle.
REQ-020 If a capture occurs while meas_valid=1 and meas_ready=0, the new result SHALL be dropped and overrun set.
REQ-021 If capture and meas_valid&meas_ready coincide, the new result SHALL be loaded, meas_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-022 stuck SHALL clear on the next captured result; overrun SHALL clear only on rst or en=0.

Reset
REQ-023 rst=1 SHALL asynchronously force state IDLE, sig_q=sig_qq=0, hcnt=lcnt=0, meas_valid=0, period=0, high_time=0, overrun=0, and stuck=0.
REQ-024 Deasserting en SHALL produce the same values synchronously, discarding any pending result.

Configuration
REQ-025 With macro FREQMEAS_CHECK_EN defined, the block SHALL add input exp_period (CNT_W+1 bits) and output mismatch (1 bit).
REQ-026 With FREQMEAS_CHECK_EN defined, mismatch SHALL be registered and asserted with meas_valid when period differs from exp_period, and cleared on acceptance.
REQ-027 Without FREQMEAS_CHECK_EN, these ports and their logic SHALL be absent.

Structure
REQ-028 A shared package iiitb_freqdiv_pkg SHALL hold the FSM state typedef (IDLE/ARM/HIGH/LOW) and the default CNT_W constant.
REQ-029 The edge detector (two flops plus rise/fall decode) SHALL be one sub-module, iiitb_edge_det; the counters, FSM, and handshake SHALL stay in the top level.

Verification
REQ-030 Scenario: en=1, sig_in divide-by-4 (2 high/2 low), meas_ready=1 -> after the second rise, every result is period=4, high_time=2; overrun=0.
REQ-031 Scenario: divide-by-5 (3 high/2 low at posedge sampling) -> period=5, high_time=3.
REQ-032 Scenario: divide-by-4, meas_ready=0 for 10 cycles -> the first result is held stable, overrun=1, and after meas_ready=1 the next result is period=4.
REQ-033 Scenario: sig_in held at 1 for 300 cycles with CNT_W=8 -> stuck=1 by cycle 256 of HIGH, with no meas_valid; resuming divide-by-4 -> stuck clears on the first result.
REQ-034 Scenario: rst pulsed mid-LOW with meas_valid=1 -> all outputs are 0 immediately, the next sequence restarts from ARM, and the first rise yields no result.
REQ-035 Scenario (FREQMEAS_CHECK_EN): exp_period=6 with divide-by-4 -> mismatch=1 alongside each meas_valid; with exp_period=4 -> mismatch=0.
